branch_predictor: RTL and testbench

Dynamic branch predictor for the RISC-V pipeline. IF queries it every cycle with the fetch PC and receives a taken/not-taken guess plus next-fetch address. The guess travels with the instruction as `jump_i`. EX resolves the branch and drives the `predictor_jump` / `predictor_jump_plus` / `predictor_jump_target` update back into this block. It is a direct-mapped BTB with one 2-bit saturating counter per entry.

---
 rtl/branch_predictor.sv | 93 +++++++++
 tb/tb_branch_predictor.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with one 2-bit saturating counter per entry.
// Queries are combinational from stored state; resolved-branch updates land on the next rising edge.
module branch_predictor #(
    parameter int INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] query_pc,
    output logic        pred_jump,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic        upd_taken,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] q_idx;
    logic [TAG_BITS-1:0]   q_tag;
    logic                  q_hit;

    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;
    logic                  u_en;
    logic [1:0]            u_ctr_inc;
    logic [1:0]            u_ctr_dec;

    // Instructions are word aligned, so the low two PC bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{query_pc[1:0], upd_pc[1:0]};

    assign q_idx = query_pc[INDEX_BITS+1:2];
    assign q_tag = query_pc[31:INDEX_BITS+2];
    assign u_idx = upd_pc[INDEX_BITS+1:2];
    assign u_tag = upd_pc[31:INDEX_BITS+2];

    always_comb begin
        q_hit       = valid_q[q_idx] && (tag_q[q_idx] == q_tag);
        pred_jump   = q_hit && ctr_q[q_idx][1];
        pred_target = query_pc + 32'd4;
        if (pred_jump) begin
            pred_target = target_q[q_idx];
        end
    end

    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_en      = rdy && upd_valid;
        u_ctr_inc = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + 2'd1;
        u_ctr_dec = (ctr_q[u_idx] == CTR_MIN) ? CTR_MIN : ctr_q[u_idx] - 2'd1;
    end

    // A taken miss evicts whatever sits at the index; a not-taken miss leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (u_en) begin
            if (u_hit) begin
                if (upd_taken) begin
                    ctr_q[u_idx]    <= u_ctr_inc;
                    target_q[u_idx] <= upd_target;
                end else begin
                    ctr_q[u_idx] <= u_ctr_dec;
                end
            end else if (upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                ctr_q[u_idx]    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic checked
// against a per-index table model built from the prediction/update rules.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] query_pc;
    logic        pred_jump;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;

    int checks;
    int errors;

    // reference table: 128 entries, idx = (pc/4) mod 128, tag = pc/512
    bit          m_valid  [128];
    logic [31:0] m_tag    [128];
    logic [31:0] m_target [128];
    int          m_ctr    [128];

    branch_predictor #(.INDEX_BITS(7)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .query_pc(query_pc),
        .pred_jump(pred_jump),
        .pred_target(pred_target),
        .upd_valid(upd_valid),
        .upd_taken(upd_taken),
        .upd_pc(upd_pc),
        .upd_target(upd_target)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 128);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / 512;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic logic exp_jump(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] exp_target(input logic [31:0] pc);
        if (exp_jump(pc)) return m_target[m_idx(pc)];
        return pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
    endtask

    task automatic model_update(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
        int i;
        i = m_idx(pc);
        if (m_hit(pc)) begin
            if (taken) begin
                m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (taken) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = m_tagof(pc);
            m_target[i] = tgt;
            m_ctr[i]    = 2;
        end
    endtask

    // driver tasks: inputs change just after the falling edge, outputs are read 1 ns later
    task automatic drive(input logic [31:0] qpc, input logic uv, input logic ut,
                         input logic [31:0] upc, input logic [31:0] utgt, input logic r);
        query_pc   = qpc;
        upd_valid  = uv;
        upd_taken  = ut;
        upd_pc     = upc;
        upd_target = utgt;
        rdy        = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && rdy && upd_valid) model_update(upd_taken, upd_pc, upd_target);
        @(negedge clk);
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        drive(32'h0000_0F00, 1'b1, taken, pc, tgt, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        drive(32'h0000_1000, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0050, 1'b1);
        checks++;
        if (pred_jump !== 1'b0) begin
            errors++;
            $display("FAIL reset_jump got %b exp 0", pred_jump);
        end
        checks++;
        if (pred_target !== 32'h0000_1004) begin
            errors++;
            $display("FAIL reset_target got %h exp 00001004", pred_target);
        end
        tick();
        tick();
        rst = 1'b1;
        drive(32'h0000_1000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_1004) begin
            errors++;
            $display("FAIL reset_release got %b/%h exp 0/00001004", pred_jump, pred_target);
        end
    endtask

    task automatic test_allocate();
        drive(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0080, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL alloc_same_cycle got %b/%h exp 0/00000104", pred_jump, pred_target);
        end
        tick();
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0080) begin
            errors++;
            $display("FAIL alloc_next_cycle got %b/%h exp 1/00000080", pred_jump, pred_target);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) upd(32'h0000_0100, 1'b1, 32'h0000_0080);
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0080) begin
            errors++;
            $display("FAIL sat_high got %b/%h exp 1/00000080", pred_jump, pred_target);
        end
        upd(32'h0000_0100, 1'b0, 32'h0);
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0080) begin
            errors++;
            $display("FAIL hyst_ctr2 got %b/%h exp 1/00000080", pred_jump, pred_target);
        end
        upd(32'h0000_0100, 1'b0, 32'h0);
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL hyst_ctr1 got %b/%h exp 0/00000104", pred_jump, pred_target);
        end
        upd(32'h0000_0100, 1'b0, 32'h0);
        upd(32'h0000_0100, 1'b0, 32'h0);
        // counter now floors at 0: one taken step must still predict not-taken
        upd(32'h0000_0100, 1'b1, 32'h0000_0088);
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL sat_low got %b/%h exp 0/00000104", pred_jump, pred_target);
        end
        upd(32'h0000_0100, 1'b1, 32'h0000_0088);
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0088) begin
            errors++;
            $display("FAIL retarget got %b/%h exp 1/00000088", pred_jump, pred_target);
        end
    endtask

    task automatic test_aliasing();
        upd(32'h0000_0100, 1'b1, 32'h0000_0080);
        upd(32'h0000_0300, 1'b1, 32'h0000_0040);
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL alias_evicted got %b/%h exp 0/00000104", pred_jump, pred_target);
        end
        drive(32'h0000_0300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0040) begin
            errors++;
            $display("FAIL alias_owner got %b/%h exp 1/00000040", pred_jump, pred_target);
        end
    endtask

    task automatic test_back_to_back();
        // evict 0x300 while querying it: the query still sees the old entry
        drive(32'h0000_0300, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0080, 1'b1);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0040) begin
            errors++;
            $display("FAIL no_bypass got %b/%h exp 1/00000040", pred_jump, pred_target);
        end
        tick();
        drive(32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0080) begin
            errors++;
            $display("FAIL b2b_realloc got %b/%h exp 1/00000080", pred_jump, pred_target);
        end
        tick();
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL b2b_decay got %b/%h exp 0/00000104", pred_jump, pred_target);
        end
        upd(32'h0000_0100, 1'b1, 32'h0000_0080);
    endtask

    task automatic test_gating();
        upd(32'h0000_0200, 1'b0, 32'h0000_0020);
        drive(32'h0000_0200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0204) begin
            errors++;
            $display("FAIL nt_no_alloc got %b/%h exp 0/00000204", pred_jump, pred_target);
        end
        drive(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0044, 1'b0);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0080) begin
            errors++;
            $display("FAIL rdy_query_live got %b/%h exp 1/00000080", pred_jump, pred_target);
        end
        tick();
        drive(32'h0000_0400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0404) begin
            errors++;
            $display("FAIL rdy_freeze got %b/%h exp 0/00000404", pred_jump, pred_target);
        end
        drive(32'h0000_0F00, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0055, 1'b1);
        tick();
        drive(32'h0000_0500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0504) begin
            errors++;
            $display("FAIL valid_gate got %b/%h exp 0/00000504", pred_jump, pred_target);
        end
    endtask

    task automatic test_wrap_async_reset();
        upd(32'hFFFF_FFFC, 1'b1, 32'h0000_0010);
        drive(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b1 || pred_target !== 32'h0000_0010) begin
            errors++;
            $display("FAIL wrap_taken got %b/%h exp 1/00000010", pred_jump, pred_target);
        end
        upd(32'hFFFF_FFFC, 1'b0, 32'h0);
        drive(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_plus4 got %b/%h exp 0/00000000", pred_jump, pred_target);
        end
        drive(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0077, 1'b1);
        checks++;
        if (pred_jump !== 1'b1) begin
            errors++;
            $display("FAIL pre_async got %b exp 1", pred_jump);
        end
        #1 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL async_reset got %b/%h exp 0/00000104", pred_jump, pred_target);
        end
        tick();
        rst = 1'b1;
        drive(32'h0000_0700, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (pred_jump !== 1'b0 || pred_target !== 32'h0000_0704) begin
            errors++;
            $display("FAIL async_lost_update got %b/%h exp 0/00000704", pred_jump, pred_target);
        end
    endtask

    task automatic test_random();
        logic [31:0] qpc;
        logic [31:0] upc;
        for (int n = 0; n < 400; n++) begin
            // small pool of indices and tags to force hits, aliasing and eviction
            upc = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 7) == 0) qpc = $urandom & 32'hFFFF_FFFC;
            else qpc = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 2);
            drive(qpc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  upc, $urandom, 1'($urandom_range(0, 9) != 0));
            checks++;
            if (pred_jump !== exp_jump(qpc)) begin
                errors++;
                $display("FAIL rand_jump pc %h got %b exp %b", qpc, pred_jump, exp_jump(qpc));
            end
            checks++;
            if (pred_target !== exp_target(qpc)) begin
                errors++;
                $display("FAIL rand_target pc %h got %h exp %h", qpc, pred_target, exp_target(qpc));
            end
            tick();
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        rdy        = 1'b0;
        query_pc   = '0;
        upd_valid  = 1'b0;
        upd_taken  = 1'b0;
        upd_pc     = '0;
        upd_target = '0;
        @(negedge clk);
        test_reset();
        test_allocate();
        test_saturation();
        test_aliasing();
        test_back_to_back();
        test_gating();
        test_wrap_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
